// File: rtl/bcdu_instr_scheduler.sv
// Queues 16-bit BCDU instructions and issues one at a time, waiting for done (push->valid: 2 cycles).
// Back-pressure via o_ready when full or in error; a BCDU error or watchdog timeout flushes the queue until cleared.
module bcdu_instr_scheduler #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   input  logic [15:0]                   i_instr,
   output logic                          o_ready,
   output logic [15:0]                   o_bcdu_instr,
   output logic                          o_bcdu_valid,
   input  logic                          i_bcdu_ready,
   input  logic                          i_bcdu_done,
   input  logic                          i_bcdu_err,
   input  logic                          i_err_clr,
   output logic                          o_busy,
   output logic                          o_err,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [WW-1:0] WD_TRIP  = WW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [15:0]   instr_q, instr_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          push, pop, flush, full;

   assign full    = (level_q == LVL_FULL);
   assign o_ready = !full && (state_q != ERR) && i_rst_n;
   assign push    = i_valid && o_ready;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
      wd_d    = wd_q;
      pop     = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (level_q != '0) begin
               instr_d = mem_q[rd_ptr_q];
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (i_bcdu_ready) begin
               pop     = 1'b1;
               wd_d    = '0;
               valid_d = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wd_q != WD_LAST) wd_d = wd_q + WW'(1);
            if (i_bcdu_done) begin
               if (i_bcdu_err) begin
                  flush   = 1'b1;
                  err_d   = 1'b1;
                  state_d = ERR;
               end else if (level_q != '0) begin
                  instr_d = mem_q[rd_ptr_q];
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end else if (push) begin
                  // Head is the word being written this cycle.
                  instr_d = i_instr;
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end else if (wd_q == WD_TRIP) begin
               flush   = 1'b1;
               err_d   = 1'b1;
               state_d = ERR;
            end
         end
         ERR: begin
            if (i_err_clr) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= i_instr;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         instr_q  <= 16'h0000;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
      end
   end

   assign o_bcdu_instr = instr_q;
   assign o_bcdu_valid = valid_q;
   assign o_err        = err_q;
   assign o_level      = level_q;
   assign o_busy       = (state_q != IDLE) || (level_q != '0);
endmodule

// File: tb/tb_bcdu_instr_scheduler.sv
// Directed scenarios plus random traffic, every cycle compared against a queue-based reference model.
module tb_bcdu_instr_scheduler;
   localparam int DEPTH = 4;
   localparam int TO    = 8;

   logic        clk = 1'b0;
   logic        rst_n, valid, ready, bvalid, bready, done, berr, clr, busy, err;
   logic [15:0] instr, binstr;
   logic [2:0]  level;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: pending words, the word on offer, and whether a word is out at the BCDU.
   logic [15:0] m_q[$];
   logic        m_offering, m_inflight, m_err;
   logic [15:0] m_word;
   int          m_wait;
   logic        pushed;

   bcdu_instr_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_instr(instr), .o_ready(ready),
      .o_bcdu_instr(binstr), .o_bcdu_valid(bvalid), .i_bcdu_ready(bready),
      .i_bcdu_done(done), .i_bcdu_err(berr), .i_err_clr(clr),
      .o_busy(busy), .o_err(err), .o_level(level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic push);
      if (!rst_n) begin
         m_q.delete();
         m_offering = 1'b0; m_inflight = 1'b0; m_err = 1'b0;
         m_word = 16'h0000; m_wait = 0;
      end else if (m_err) begin
         if (clr) m_err = 1'b0;
      end else if (m_offering) begin
         if (bready) begin
            void'(m_q.pop_front());
            m_offering = 1'b0; m_inflight = 1'b1; m_wait = 0;
         end
         if (push) m_q.push_back(instr);
      end else if (m_inflight) begin
         if (done && berr) begin
            m_inflight = 1'b0; m_err = 1'b1; m_q.delete();
         end else if (done) begin
            m_inflight = 1'b0;
            if (push) m_q.push_back(instr);
            if (m_q.size() > 0) begin m_offering = 1'b1; m_word = m_q[0]; end
         end else if (m_wait + 1 == TO - 1) begin
            // This cycle completes TO-1 cycles of waiting: give up.
            m_inflight = 1'b0; m_err = 1'b1; m_q.delete();
         end else begin
            m_wait++;
            if (push) m_q.push_back(instr);
         end
      end else begin
         if (m_q.size() > 0) begin m_offering = 1'b1; m_word = m_q[0]; end
         if (push) m_q.push_back(instr);
      end
   endtask

   task automatic cyc();
      logic mready, push;
      #2;
      mready = rst_n && !m_err && (m_q.size() < DEPTH);
      chk("ready", 32'(ready), 32'(mready));
      push = valid && mready;
      @(posedge clk);
      model_step(push);
      pushed = push;
      #1;
      if (push) valid = 1'b0;
      chk("bvalid", 32'(bvalid), 32'(m_offering));
      chk("binstr", 32'(binstr), 32'(m_word));
      chk("err", 32'(err), 32'(m_err));
      chk("level", 32'(level), 32'(m_q.size()));
      chk("busy", 32'(busy), 32'(m_offering || m_inflight || m_err || (m_q.size() != 0)));
   endtask

   task automatic idle_in();
      valid = 1'b0; bready = 1'b0; done = 1'b0; berr = 1'b0; clr = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] w);
      valid = 1'b1; instr = w;
      for (int n = 0; n < 20 && valid; n++) cyc();
      chk("push_accepted", 32'(valid), 32'(0));
      valid = 1'b0;
   endtask

   task automatic wait_bvalid();
      for (int n = 0; n < 20 && !bvalid; n++) cyc();
      chk("wait_bvalid", 32'(bvalid), 32'(1));
   endtask

   initial begin
      int k, n;
      idle_in(); instr = 16'h0; rst_n = 1'b0;
      m_q.delete(); m_offering = 0; m_inflight = 0; m_err = 0; m_word = 0; m_wait = 0;

      // 1: reset held 3 cycles
      repeat (3) cyc();
      rst_n = 1'b1; #1;
      chk("t1_ready", 32'(ready), 32'(1));
      chk("t1_bvalid", 32'(bvalid), 32'(0));
      chk("t1_err", 32'(err), 32'(0));
      chk("t1_level", 32'(level), 32'(0));

      // 2: single instruction, 2-cycle latency, valid for exactly one cycle
      bready = 1'b1; valid = 1'b1; instr = 16'h1234;
      cyc();
      chk("t2_n1_valid", 32'(bvalid), 32'(0));
      cyc();
      chk("t2_n2_valid", 32'(bvalid), 32'(1));
      chk("t2_n2_instr", 32'(binstr), 32'(16'h1234));
      cyc();
      chk("t2_n3_valid", 32'(bvalid), 32'(0));
      repeat (4) cyc();
      done = 1'b1; cyc(); done = 1'b0;
      chk("t2_busy", 32'(busy), 32'(0));
      bready = 1'b0;

      // 3: overfill with BCDU stalled, then drain in order
      k = 1;
      for (int c = 0; c < 8; c++) begin
         valid = 1'b1; instr = 16'hA000 + 16'(k);
         cyc();
         if (pushed) k++;
      end
      chk("t3_accepted", 32'(k), 32'(5));
      chk("t3_level", 32'(level), 32'(4));
      chk("t3_ready", 32'(ready), 32'(0));
      bready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         for (n = 0; n < 20 && !bvalid; n++) cyc();
         chk("t3_order", 32'(binstr), 32'(16'hA001 + i));
         cyc(); cyc();
         done = 1'b1; cyc(); done = 1'b0;
         if (i < 4) chk("t3_direct", 32'(bvalid), 32'(1));
      end
      valid = 1'b0; cyc();
      chk("t3_idle", 32'(busy), 32'(0));

      // 4: BCDU error with two words queued
      push_word(16'h0F0F);
      wait_bvalid();
      chk("t4_instr", 32'(binstr), 32'(16'h0F0F));
      cyc();
      push_word(16'h1111);
      push_word(16'h2222);
      chk("t4_level_pre", 32'(level), 32'(2));
      done = 1'b1; berr = 1'b1; cyc(); done = 1'b0; berr = 1'b0;
      chk("t4_err", 32'(err), 32'(1));
      chk("t4_level", 32'(level), 32'(0));
      chk("t4_ready", 32'(ready), 32'(0));
      k = 0;
      repeat (4) begin cyc(); if (bvalid) k++; end
      chk("t4_no_issue", 32'(k), 32'(0));
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("t4_clr_err", 32'(err), 32'(0));
      chk("t4_clr_ready", 32'(ready), 32'(1));
      chk("t4_clr_busy", 32'(busy), 32'(0));

      // 5: watchdog trips TO-1 cycles after WAIT entry; done in that cycle wins
      push_word(16'h0055);
      wait_bvalid();
      cyc();
      for (n = 1; n <= 12; n++) begin
         cyc();
         if (err) break;
      end
      chk("t5_timeout_cycles", 32'(n), 32'(TO - 1));
      clr = 1'b1; cyc(); clr = 1'b0;
      push_word(16'h0066);
      wait_bvalid();
      cyc();
      repeat (TO - 2) cyc();
      done = 1'b1; cyc(); done = 1'b0;
      chk("t5_done_wins_err", 32'(err), 32'(0));
      chk("t5_done_wins_busy", 32'(busy), 32'(0));

      // 6: reset in WAIT with three queued, then a stray done
      push_word(16'h0A0A);
      wait_bvalid();
      cyc();
      push_word(16'h0B01); push_word(16'h0B02); push_word(16'h0B03);
      chk("t6_level_pre", 32'(level), 32'(3));
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      chk("t6_level", 32'(level), 32'(0));
      chk("t6_busy", 32'(busy), 32'(0));
      done = 1'b1; cyc(); done = 1'b0;
      cyc();
      chk("t6_no_issue", 32'(bvalid), 32'(0));
      chk("t6_no_err", 32'(err), 32'(0));
      bready = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (!valid && ($urandom_range(0, 1) == 1)) begin
            valid = 1'b1; instr = 16'($urandom);
         end
         bready = ($urandom_range(0, 2) != 0);
         done   = ($urandom_range(0, 3) == 0);
         berr   = ($urandom_range(0, 7) == 0);
         clr    = ($urandom_range(0, 5) == 0);
         rst_n  = ($urandom_range(0, 199) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
